is_uart_rx_param: RTL and testbench
===================================

// Module: is_uart_rx_param
// PURPOSE
//  Parametrised UART receiver: oversampled start detection, 3-sample majority vote at mid-bit,
//  configurable data width, parity mode and stop count. Flags parity error, framing error and break.
//  Holds received word in a valid/ready output register with overrun signalling. Sits between the
//  rxd input register and the controller RX FIFO; oversample tick comes from the shared baud divider.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, 5..8, LSB first
//  PARITY      0   0=none 1=odd 2=even 3=mark(1) 4=space(0)
//  STOP_BITS   1   stop bits checked, 1 or 2
//  OVERSAMPLE  16  os_ce_i ticks per bit, even, >=8
// PORTS
//  clk_i        in   1          system clock
//  rstn_i       in   1          asynchronous reset, active low
//  rxd_rg_i     in   1          serial line, already synchronised/registered, idle high
//  os_ce_i      in   1          oversample tick, 1-cycle pulse at OVERSAMPLE x baud
//  rx_en_i      in   1          0: no new start detected (frame in progress completes)
//  rx_data_o    out  DATA_BITS  received word
//  rx_perr_o    out  1          parity error for rx_data_o (0 when PARITY=0)
//  rx_ferr_o    out  1          framing error (any sampled stop bit = 0) for rx_data_o
//  rx_valid_o   out  1          output register holds unread word
//  rx_ready_i   in   1          consumer accepts word when rx_valid_o & rx_ready_i
//  overrun_o    out  1          1-cycle pulse: frame completed while word still unread
//  break_o      out  1          1-cycle pulse: break detected
//  busy_o       out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rstn_i=0): state IDLE, all counters 0, rx_data_o=0, rx_perr_o=0, rx_ferr_o=0,
//   rx_valid_o=0, overrun_o=0, break_o=0, busy_o=0. Reset mid-frame aborts frame, no output.
//  All FSM/counter updates occur only on cycles with os_ce_i=1, except the output handshake.
//  os_cnt counts 0..OVERSAMPLE-1 per bit; H=OVERSAMPLE/2. Samples at os_cnt=H-1,H,H+1;
//   bit value = majority of 3, decided at os_cnt=H+1.
//  States: IDLE, START, DATA, PARITY, STOP, BRK.
//   IDLE:   rx_en_i=1 & rxd_rg_i=0 on tick -> START, os_cnt=0 (this tick is tick 0).
//   START:  decision=1 (false start) -> IDLE; decision=0 -> wait os_cnt wrap -> DATA, bit_cnt=0.
//   DATA:   decision shifted into shift reg LSB first; after bit DATA_BITS-1 -> PARITY (PARITY!=0)
//           else STOP.
//   PARITY: perr = decision != expected (odd: XOR(data)^1; even: XOR(data); mark: 1; space: 0).
//   STOP:   at each stop decision, 0 sets ferr. After last stop decision -> IDLE immediately
//           (no wait for bit end), so a start edge in the following half-bit is caught.
//           If data all 0, parity bit (if any) 0 and first stop 0: break -> break_o pulse, go BRK,
//           no word delivered, no overrun.
//   BRK:    stay until rxd_rg_i=1 on a tick -> IDLE.
//  Frame completion: on the cycle after the last stop decision tick:
//   - rx_valid_o=0 or (rx_valid_o & rx_ready_i same cycle): load data/perr/ferr, rx_valid_o=1.
//   - rx_valid_o=1 & rx_ready_i=0: new frame dropped, old word kept, overrun_o pulses 1 cycle.
//  Handshake: rx_valid_o stays high with stable data until rx_valid_o & rx_ready_i; clears next
//   cycle unless a new frame loads the same cycle (stays high, new data).
//  rx_en_i deassert mid-frame: frame completes normally; only IDLE start detection gated.
//  Widths: os_cnt $clog2(OVERSAMPLE) bits, wraps OVERSAMPLE-1 -> 0; bit_cnt 3 bits.
//  busy_o = (state != IDLE), combinational from state register.
// TESTING
//  8N1, OVERSAMPLE=16, send 0xA5 -> rx_data_o=0xA5, perr=0, ferr=0, rx_valid_o held until ready.
//  8E1, send 0x03 with parity bit 1 -> rx_data_o=0x03, rx_perr_o=1; repeat with parity bit 0 -> perr=0.
//  Low glitch 4 ticks in IDLE -> START then IDLE, no rx_valid_o, busy_o returns 0.
//  8N2, second stop bit 0, data 0x5A -> rx_data_o=0x5A, rx_ferr_o=1. Line low 2 frames -> one
//   break_o pulse, no rx_valid_o, BRK until rxd high.
//  rx_ready_i=0, send 0x11 then 0x22 -> overrun_o one pulse, rx_data_o stays 0x11.
//  rstn_i low during DATA bit 3 -> all outputs 0 immediately; next 0x7E frame received correctly.

Source files
------------

// File: rtl/is_uart_rx_param.sv
// rtl/is_uart_rx_param.sv - parametrised oversampling UART receiver with valid/ready output register
module is_uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rxd_rg_i,
  input  logic                 os_ce_i,
  input  logic                 rx_en_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int H   = OVERSAMPLE / 2;

  localparam logic [OSW-1:0] OS_S0   = OSW'(H - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(H);
  localparam logic [OSW-1:0] OS_DEC  = OSW'(H + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BRK   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 brk_q, brk_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 operr_q, operr_d;
  logic                 oferr_q, oferr_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic                 dec;
  logic                 par_exp;
  logic                 frame_zero;
  logic [OSW-1:0]       os_next;

  // Majority of the two stored mid-bit samples and the live third sample.
  assign dec = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_rg_i) | (smp_q[1] & rxd_rg_i);

  always_comb begin
    par_exp = 1'b0;
    case (PARITY)
      1:       par_exp = ~^shift_q;
      2:       par_exp = ^shift_q;
      3:       par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  assign frame_zero = (shift_q == '0) && ((PARITY == 0) || !par_bit_q);
  assign os_next    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    brk_d     = 1'b0;
    if (os_ce_i) begin
      if (state_q != ST_IDLE && state_q != ST_BRK) begin
        os_cnt_d = os_next;
        if (os_cnt_q == OS_S0) smp_d[0] = rxd_rg_i;
        if (os_cnt_q == OS_S1) smp_d[1] = rxd_rg_i;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_en_i && !rxd_rg_i) begin
            state_d  = ST_START;
            os_cnt_d = '0;
            perr_d   = 1'b0;
            ferr_d   = 1'b0;
          end
        end
        ST_START: begin
          if (os_cnt_q == OS_DEC && dec) begin
            state_d  = ST_IDLE;
            os_cnt_d = '0;
          end else if (os_cnt_q == OS_LAST) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          if (os_cnt_q == OS_DEC) shift_d = {dec, shift_q[DATA_BITS-1:1]};
          if (os_cnt_q == OS_LAST) begin
            if (bit_cnt_q == LAST_DATA) begin
              state_d   = (PARITY != 0) ? ST_PAR : ST_STOP;
              bit_cnt_d = 3'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PAR: begin
          if (os_cnt_q == OS_DEC) begin
            par_bit_d = dec;
            perr_d    = (dec != par_exp);
          end
          if (os_cnt_q == OS_LAST) begin
            state_d   = ST_STOP;
            bit_cnt_d = 3'd0;
          end
        end
        ST_STOP: begin
          if (os_cnt_q == OS_DEC) begin
            if (!dec) ferr_d = 1'b1;
            // Leave on the decision tick so a start edge in the next half-bit is caught.
            if (bit_cnt_q == 3'd0 && !dec && frame_zero) begin
              state_d  = ST_BRK;
              brk_d    = 1'b1;
              os_cnt_d = '0;
            end else if (bit_cnt_q == LAST_STOP) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              os_cnt_d = '0;
            end
          end else if (os_cnt_q == OS_LAST) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_BRK: begin
          if (rxd_rg_i) state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          os_cnt_d = '0;
        end
      endcase
    end
  end

  // Output register: a completing frame either loads (free or drained this cycle) or overruns.
  always_comb begin
    data_d  = data_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        operr_d = perr_q;
        oferr_d = ferr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= 3'd0;
      smp_q     <= 2'b00;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      brk_q     <= 1'b0;
      data_q    <= '0;
      operr_q   <= 1'b0;
      oferr_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      brk_q     <= brk_d;
      data_q    <= data_d;
      operr_q   <= operr_d;
      oferr_q   <= oferr_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_o  = data_q;
  assign rx_perr_o  = operr_q;
  assign rx_ferr_o  = oferr_q;
  assign rx_valid_o = valid_q;
  assign overrun_o  = ovr_q;
  assign break_o    = brk_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_is_uart_rx_param.sv
// tb/tb_is_uart_rx_param.sv - directed scoreboard bench for 8N1, 8E1 and 8N2 receivers
module tb_is_uart_rx_param;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            os_ce = 1'b0;
  logic [1:0]      div = 2'd0;
  logic            en = 1'b1;
  logic [2:0]      rxd = 3'b111;
  logic [2:0]      ready = 3'b000;
  logic [2:0][7:0] data;
  logic [2:0]      perr, ferr, valid, ovr, brk, busy;

  int checks = 0;
  int errors = 0;
  int brk_cnt[3] = '{0, 0, 0};
  int ovr_cnt[3] = '{0, 0, 0};

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // One oversample tick every fourth clock, changing away from the sampling edge.
  always @(negedge clk) begin
    div   <= div + 2'd1;
    os_ce <= (div == 2'd3);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  is_uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk_i(clk), .rstn_i(rstn), .rxd_rg_i(rxd[0]), .os_ce_i(os_ce), .rx_en_i(en),
    .rx_data_o(data[0]), .rx_perr_o(perr[0]), .rx_ferr_o(ferr[0]), .rx_valid_o(valid[0]),
    .rx_ready_i(ready[0]), .overrun_o(ovr[0]), .break_o(brk[0]), .busy_o(busy[0]));

  is_uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
    .clk_i(clk), .rstn_i(rstn), .rxd_rg_i(rxd[1]), .os_ce_i(os_ce), .rx_en_i(en),
    .rx_data_o(data[1]), .rx_perr_o(perr[1]), .rx_ferr_o(ferr[1]), .rx_valid_o(valid[1]),
    .rx_ready_i(ready[1]), .overrun_o(ovr[1]), .break_o(brk[1]), .busy_o(busy[1]));

  is_uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
    .clk_i(clk), .rstn_i(rstn), .rxd_rg_i(rxd[2]), .os_ce_i(os_ce), .rx_en_i(en),
    .rx_data_o(data[2]), .rx_perr_o(perr[2]), .rx_ferr_o(ferr[2]), .rx_valid_o(valid[2]),
    .rx_ready_i(ready[2]), .overrun_o(ovr[2]), .break_o(brk[2]), .busy_o(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_ce) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input int idx, input logic v);
    rxd[idx] = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic s0, input logic s1, input int nstop);
    send_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(idx, d[i]);
    if (has_par) send_bit(idx, pbit);
    send_bit(idx, s0);
    if (nstop == 2) send_bit(idx, s1);
    rxd[idx] = 1'b1;
    wait_ticks(4);
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.idx = idx; e.d = d; e.pe = pe; e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic consume(input int idx);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!valid[idx] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", {31'd0, valid[idx]}, 32'd1);
    if (valid[idx]) begin
      check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_idx", idx, e.idx);
        check("rx_data", {24'd0, data[idx]}, {24'd0, e.d});
        check("rx_perr", {31'd0, perr[idx]}, {31'd0, e.pe});
        check("rx_ferr", {31'd0, ferr[idx]}, {31'd0, e.fe});
      end
      ready[idx] = 1'b1;
      @(posedge clk);
      #1 ready[idx] = 1'b0;
      @(negedge clk);
      check("valid_clear", {31'd0, valid[idx]}, 32'd0);
    end
  endtask

  initial begin
    int b0, o0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_data", {24'd0, data[i]}, 32'd0);
      check("rst_flags", {26'd0, perr[i], ferr[i], valid[i], ovr[i], brk[i], busy[i]}, 32'd0);
    end
    rstn = 1'b1;
    wait_ticks(20);

    // 8N1 0xA5, held until ready
    push(0, 8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    repeat (100) @(negedge clk);
    check("hold_valid", {31'd0, valid[0]}, 32'd1);
    check("hold_data", {24'd0, data[0]}, 32'hA5);
    consume(0);

    // 8E1 0x03: parity bit 1 is wrong for even, 0 is right
    push(1, 8'h03, 1'b1, 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    consume(1);
    push(1, 8'h03, 1'b0, 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    consume(1);

    // 4-tick glitch: false start
    rxd[0] = 1'b0;
    wait_ticks(4);
    rxd[0] = 1'b1;
    check("glitch_busy", {31'd0, busy[0]}, 32'd1);
    wait_ticks(16);
    check("glitch_idle", {31'd0, busy[0]}, 32'd0);
    check("glitch_novalid", {31'd0, valid[0]}, 32'd0);

    // rx_en_i low blocks start detection
    en = 1'b0;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("en_novalid", {31'd0, valid[0]}, 32'd0);
    check("en_idle", {31'd0, busy[0]}, 32'd0);
    en = 1'b1;

    // 8N2 with second stop low
    push(2, 8'h5A, 1'b0, 1'b1);
    send_frame(2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    consume(2);

    // break: line low for two frames
    wait_ticks(20);
    b0 = brk_cnt[2];
    rxd[2] = 1'b0;
    wait_ticks(2 * 11 * 16);
    check("brk_pulse", brk_cnt[2] - b0, 32'd1);
    check("brk_novalid", {31'd0, valid[2]}, 32'd0);
    check("brk_busy", {31'd0, busy[2]}, 32'd1);
    rxd[2] = 1'b1;
    wait_ticks(2);
    check("brk_exit", {31'd0, busy[2]}, 32'd0);
    check("brk_once", brk_cnt[2] - b0, 32'd1);

    // overrun: second word dropped
    o0 = ovr_cnt[0];
    push(0, 8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    @(negedge clk);
    check("ovr_pulse", ovr_cnt[0] - o0, 32'd1);
    check("ovr_keep", {24'd0, data[0]}, 32'h11);
    consume(0);

    // reset during DATA bit 3 clears a pending word and aborts the frame
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    @(negedge clk);
    check("pend_valid", {31'd0, valid[1]}, 32'd1);
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    rxd[0] = 1'b0;
    wait_ticks(8);
    check("mid_busy", {31'd0, busy[0]}, 32'd1);
    rstn = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy[0]}, 32'd0);
    check("arst_valid", {31'd0, valid[1]}, 32'd0);
    check("arst_data", {24'd0, data[1]}, 32'd0);
    rxd[0] = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    wait_ticks(20);
    push(0, 8'h7E, 1'b0, 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    consume(0);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
